// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared accelerator definitions: arbiter FSM encodings and FIFO write-port defaults.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  localparam int FIFO_DWIDTH_DEF = 8;
  localparam int ARB_NREQ_DEF    = 4;
  localparam int ARB_BURST_DEF   = 4;
  localparam int BEAT_W          = 4;

  // Modulo-n wrap by compare, so non-power-of-two requester counts rotate correctly.
  function automatic int rr_wrap(input int v, input int n);
    return (v >= n) ? v - n : v;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after rr_ptr, wrapping modulo NREQ.
module fifo_wr_arbiter_rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ = ARB_NREQ_DEF,
  parameter int IDW  = $clog2(ARB_NREQ_DEF)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic            found,
  output logic [IDW-1:0]  idx
);

  // Walk offsets from farthest to nearest so the smallest offset wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[IDW'(rr_wrap(int'(rr_ptr) + k, NREQ))]) begin
        found = 1'b1;
        idx   = IDW'(rr_wrap(int'(rr_ptr) + k, NREQ));
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NREQ producers.
//   state    | meaning
//   ST_IDLE  | no owner; pick next requester from rr_ptr
//   ST_GRANT | owner drives the FIFO port for up to BURST words
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ   = ARB_NREQ_DEF,
  parameter int DWIDTH = FIFO_DWIDTH_DEF,
  parameter int BURST  = ARB_BURST_DEF,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DWIDTH-1:0]   data,
  output logic [NREQ-1:0]          ack,
  input  logic                     fifo_full,
  output logic                     fifo_wr,
  output logic [DWIDTH-1:0]        fifo_wdata,
  output logic [IDW-1:0]           grant_id,
  output logic                     busy
);

  arb_state_e        state_q, state_d;
  logic [IDW-1:0]    owner_q, owner_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  logic              pick_found;
  logic [IDW-1:0]    pick_idx;
  logic              owner_req;
  logic              xfer;
  logic              last_beat;
  logic [IDW-1:0]    owner_nxt;

  fifo_wr_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  // Port muxing stays combinational so a word is written in the same cycle it is acked.
  always_comb begin
    owner_req  = 1'b0;
    fifo_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == IDW'(i)) begin
        owner_req  = req[i];
        fifo_wdata = data[i*DWIDTH +: DWIDTH];
      end
    end
    xfer      = (state_q == ST_GRANT) && owner_req && !fifo_full;
    last_beat = (beat_q == BEAT_W'(BURST - 1));
    owner_nxt = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
    fifo_wr   = xfer;
    ack       = '0;
    for (int i = 0; i < NREQ; i++) begin
      ack[i] = xfer && (owner_q == IDW'(i));
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    beat_d   = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_GRANT;
          owner_d = pick_idx;
          beat_d  = '0;
        end
      end
      ST_GRANT: begin
        if (!owner_req || (xfer && last_beat)) begin
          state_d  = ST_IDLE;
          rr_ptr_d = owner_nxt;
          beat_d   = '0;
        end else if (xfer) begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
    end
  end

  assign grant_id = owner_q;
  assign busy     = (state_q == ST_GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: expected FIFO words are queued, a negedge monitor checks every write.
module tb_fifo_wr_arbiter;

  localparam int NREQ   = 4;
  localparam int DWIDTH = 8;
  localparam int BURST  = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        req;
  logic [NREQ*DWIDTH-1:0] data;
  logic [NREQ-1:0]        ack;
  logic                   fifo_full;
  logic                   fifo_wr;
  logic [DWIDTH-1:0]      fifo_wdata;
  logic [1:0]             grant_id;
  logic                   busy;

  fifo_wr_arbiter #(.NREQ(NREQ), .DWIDTH(DWIDTH), .BURST(BURST)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .data       (data),
    .ack        (ack),
    .fifo_full  (fifo_full),
    .fifo_wr    (fifo_wr),
    .fifo_wdata (fifo_wdata),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  bit         mon_en = 1'b0;

  int         left[NREQ];
  logic [7:0] base[NREQ];
  logic [7:0] cnt[NREQ];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && (ack !== '0 || fifo_wr !== 1'b0)) begin
      checks++;
      if (fifo_wr !== 1'b1 || !$onehot(ack)) begin
        failures++;
        $display("FAIL ack_wr actual fifo_wr=%b ack=%b required fifo_wr=1 ack one-hot", fifo_wr, ack);
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual=%0h required no write", fifo_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if (fifo_wdata !== mon_exp) begin
          failures++;
          $display("FAIL wdata actual=%0h required=%0h", fifo_wdata, mon_exp);
        end
      end
    end
  end

  // Producer model: req held while words remain, data advances after each ack.
  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      req[i] = (left[i] > 0);
      data[i*DWIDTH +: DWIDTH] = base[i] + cnt[i];
    end
  endtask

  task automatic cycle(output logic [NREQ-1:0] a, output logic b,
                       output logic [1:0] g, output logic [7:0] wd);
    @(negedge clk);
    a  = ack;
    b  = busy;
    g  = grant_id;
    wd = fifo_wdata;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (a[i]) begin
        cnt[i] = cnt[i] + 8'd1;
        if (left[i] > 0) left[i] = left[i] - 1;
      end
    end
    apply();
  endtask

  task automatic do_reset();
    logic [NREQ-1:0] a;
    logic b;
    logic [1:0] g;
    logic [7:0] wd;
    for (int i = 0; i < NREQ; i++) begin
      left[i] = 0;
      cnt[i]  = 8'd0;
    end
    fifo_full = 1'b0;
    reset     = 1'b1;
    apply();
    cycle(a, b, g, wd);
    reset = 1'b0;
    apply();
  endtask

  initial begin
    logic [NREQ-1:0] a;
    logic            b;
    logic [1:0]      g;
    logic [7:0]      wd;
    logic [12:0]     pat_ack;
    logic [12:0]     pat_busy;
    logic [9:0]      pat_b4;
    int              gseq[5];

    req       = '0;
    data      = '0;
    fifo_full = 1'b0;
    reset     = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      left[i] = 0;
      cnt[i]  = 8'd0;
      base[i] = 8'h00;
    end
    base[0] = 8'h5A;
    apply();
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Reset state
    cycle(a, b, g, wd);
    chk("rst_busy", b, 0);
    chk("rst_gid", g, 0);
    chk("rst_ack", a, 0);
    chk("rst_wdata", wd, 8'h5A);

    // Single requester 2, nine words
    reset   = 1'b0;
    base[2] = 8'hA0;
    left[2] = 9;
    apply();
    for (int k = 0; k < 9; k++) exp_q.push_back(8'(8'hA0 + k));
    pat_ack  = 13'b0101111011110;
    pat_busy = 13'b1101111011110;
    for (int c = 0; c < 13; c++) begin
      cycle(a, b, g, wd);
      chk($sformatf("t1_ack_c%0d", c), a[2], pat_ack[c]);
      chk($sformatf("t1_busy_c%0d", c), b, pat_busy[c]);
      if (pat_busy[c]) chk("t1_gid", g, 2);
    end
    cycle(a, b, g, wd);
    chk("t1_end_busy", b, 0);

    // All four requesters active from reset release
    reset   = 1'b1;
    left[0] = 8;
    for (int i = 1; i < NREQ; i++) left[i] = 4;
    for (int i = 0; i < NREQ; i++) begin
      cnt[i]  = 8'd0;
      base[i] = 8'(8'h10 * i);
    end
    apply();
    cycle(a, b, g, wd);
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++)
      for (int k = 0; k < 4; k++) exp_q.push_back(8'(8'h10 * i + k));
    for (int k = 4; k < 8; k++) exp_q.push_back(8'(k));
    gseq = '{0, 1, 2, 3, 0};
    for (int c = 0; c < 26; c++) begin
      cycle(a, b, g, wd);
      if (c % 5 == 0) chk($sformatf("t2_gap_busy_c%0d", c), b, 0);
      if (c % 5 == 1) begin
        chk($sformatf("t2_gid_c%0d", c), g, gseq[c/5]);
        chk($sformatf("t2_busy_c%0d", c), b, 1);
      end
    end

    // Backpressure on requester 1
    do_reset();
    base[1] = 8'h40;
    left[1] = 4;
    apply();
    for (int k = 0; k < 4; k++) exp_q.push_back(8'(8'h40 + k));
    for (int c = 0; c < 10; c++) begin
      fifo_full = (c >= 2 && c <= 5);
      cycle(a, b, g, wd);
      chk($sformatf("t3_ack_c%0d", c), a, (c == 1 || (c >= 6 && c <= 8)) ? 4'b0010 : 4'b0000);
      if (c >= 1 && c <= 8) begin
        chk($sformatf("t3_gid_c%0d", c), g, 1);
        chk($sformatf("t3_busy_c%0d", c), b, 1);
      end
      if (c == 9) chk("t3_release_busy", b, 0);
    end
    fifo_full = 1'b0;

    // Early drop by requester 3, pending requester 0
    do_reset();
    base[3] = 8'h60;
    left[3] = 2;
    apply();
    exp_q.push_back(8'h60);
    exp_q.push_back(8'h61);
    for (int k = 0; k < 3; k++) exp_q.push_back(8'(8'h70 + k));
    pat_b4 = 10'b0111101110;
    for (int c = 0; c < 10; c++) begin
      cycle(a, b, g, wd);
      chk($sformatf("t4_busy_c%0d", c), b, pat_b4[c]);
      chk($sformatf("t4_ack_c%0d", c), a,
          (c == 1 || c == 2) ? 4'b1000 : ((c >= 5 && c <= 7) ? 4'b0001 : 4'b0000));
      if (c == 3) chk("t4_gid_drop", g, 3);
      if (c == 5) chk("t4_gid_next", g, 0);
      if (c == 0) begin
        base[0] = 8'h70;
        left[0] = 3;
        apply();
      end
    end

    // Reset mid-burst of requester 1
    do_reset();
    base[1] = 8'h80;
    left[1] = 4;
    apply();
    for (int k = 0; k < 4; k++) exp_q.push_back(8'(8'h80 + k));
    exp_q.push_back(8'h90);
    exp_q.push_back(8'h91);
    cycle(a, b, g, wd);
    cycle(a, b, g, wd);
    chk("t5_ack_b0", a, 4'b0010);
    cycle(a, b, g, wd);
    reset = 1'b1;
    cycle(a, b, g, wd);
    chk("t5_ack_in_reset", a, 4'b0010);
    reset   = 1'b0;
    base[3] = 8'h90;
    left[3] = 2;
    apply();
    cycle(a, b, g, wd);
    chk("t5_busy_after_rst", b, 0);
    chk("t5_gid_after_rst", g, 0);
    chk("t5_ack_after_rst", a, 0);
    cycle(a, b, g, wd);
    chk("t5_first_gid", g, 1);
    chk("t5_first_ack", a, 4'b0010);
    for (int c = 6; c < 12; c++) begin
      cycle(a, b, g, wd);
      if (c == 8) begin
        chk("t5_second_gid", g, 3);
        chk("t5_second_ack", a, 4'b1000);
      end
      if (c == 11) chk("t5_end_busy", b, 0);
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
